mac_tx_arbiter: RTL and testbench

Two-requester transmit arbiter that shares the single MAC transmit byte stream (the `mac_txv`/`mac_txd` input of the RGMII transmit path) between protocol engines, e.g. the ARP responder and the UDP/ICMP sender. It grants whole frames round-robin and forwards the granted requester's bytes with one cycle of latency. It enforces the Ethernet inter-frame gap and guards against stalled or runaway requesters. Runs entirely in the MAC transmit clock domain, which equals the RGMII receive clock.

---
 rtl/mac_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// Round-robin whole-frame arbiter feeding the MAC TX byte stream; 1-cycle data latency.
// Enforces inter-frame gap, withdraws idle grants after a start timeout, truncates oversize frames.
module mac_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_FRAME     = 1536
) (
    input  logic       mac_txc,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       vld0,
    input  logic       vld1,
    input  logic [7:0] dat0,
    input  logic [7:0] dat1,
    output logic       mac_txv,
    output logic [7:0] mac_txd,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_trunc
);
    localparam int BW = $clog2(MAX_FRAME + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int IW = $clog2(IFG_CYCLES + 1);
    localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_FRAME);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SEND, S_IFG} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          txv_q, txv_d;
    logic [7:0]    txd_q, txd_d;
    logic          tmo_q, tmo_d, trunc_q, trunc_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic          pick;
    logic          sel_vld;
    logic [7:0]    sel_dat;

    // last_q doubles as the owner index while a grant is held
    assign sel_vld = last_q ? vld1 : vld0;
    assign sel_dat = last_q ? dat1 : dat0;

    always_ff @(posedge mac_txc) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            txv_q      <= 1'b0;
            txd_q      <= 8'h00;
            tmo_q      <= 1'b0;
            trunc_q    <= 1'b0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            ifg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            txv_q      <= txv_d;
            txd_q      <= txd_d;
            tmo_q      <= tmo_d;
            trunc_q    <= trunc_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        txv_d      = 1'b0;
        txd_d      = txd_q;
        tmo_d      = 1'b0;
        trunc_d    = 1'b0;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        pick       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    pick      = (req0 && req1) ? ~last_q : req1;
                    last_d    = pick;
                    gnt0_d    = ~pick;
                    gnt1_d    = pick;
                    tmo_cnt_d = '0;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                if (sel_vld) begin
                    txv_d      = 1'b1;
                    txd_d      = sel_dat;
                    byte_cnt_d = BW'(1);
                    state_d    = S_SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    tmo_d     = 1'b1;
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (!sel_vld) begin
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    txd_d     = sel_dat;
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
                end else if (byte_cnt_q == BYTE_MAX) begin
                    // one byte too many: cut the frame, the rest is dropped
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    trunc_d   = 1'b1;
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
                end else begin
                    txv_d      = 1'b1;
                    txd_d      = sel_dat;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign mac_txv     = txv_q;
    assign mac_txd     = txd_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = tmo_q;
    assign err_trunc   = trunc_q;
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: frames, contention, timeout, truncation, reset, req drop.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;
    logic       mac_txc = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       vld0 = 1'b0, vld1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       gnt0, gnt1, mac_txv, busy, err_timeout, err_trunc;
    logic [7:0] mac_txd;

    int checks = 0;
    int errors = 0;
    int txv_cnt, bad_cnt, trunc_cnt, gnt_lo, first_idle;

    mac_tx_arbiter dut (
        .mac_txc(mac_txc), .rst(rst),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .vld0(vld0), .vld1(vld1), .dat0(dat0), .dat1(dat1),
        .mac_txv(mac_txv), .mac_txd(mac_txd), .busy(busy),
        .err_timeout(err_timeout), .err_trunc(err_trunc)
    );

    always #5 mac_txc = ~mac_txc;

    task automatic step();
        @(posedge mac_txc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive n bytes base+i from requester own, observing the output one edge later.
    task automatic stream(input int own, input int n, input logic [7:0] base,
                          input bit noise, input int drop_req_at);
        logic [7:0] exp_b;
        txv_cnt = 0; bad_cnt = 0; trunc_cnt = 0; gnt_lo = 0; first_idle = -1;
        for (int i = 0; i < n; i++) begin
            exp_b = base + 8'(i);
            if (own == 0) begin
                vld0 = 1'b1; dat0 = exp_b;
                if (noise) begin vld1 = 1'b1; dat1 = 8'hEE; end
                if (i == drop_req_at) req0 = 1'b0;
            end else begin
                vld1 = 1'b1; dat1 = exp_b;
                if (noise) begin vld0 = 1'b1; dat0 = 8'hEE; end
                if (i == drop_req_at) req1 = 1'b0;
            end
            step();
            if (mac_txv) begin
                txv_cnt++;
                if (mac_txd !== exp_b) bad_cnt++;
            end
            if (err_trunc) trunc_cnt++;
            if (((own == 0) ? gnt0 : gnt1) !== 1'b1) gnt_lo++;
            if (!busy && first_idle < 0) first_idle = i;
        end
    endtask

    task automatic measure_ifg(input string tag, input int exp_len);
        int n = 0;
        int txb = 0;
        while (busy && n < 100) begin
            if (mac_txv) txb++;
            n++;
            step();
        end
        chk({tag, "_ifg_len"}, 32'(n), 32'(exp_len));
        chk({tag, "_ifg_txv"}, 32'(txb), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        vld0 = 1'b0; vld1 = 1'b0;
        step();
        chk({tag, "_end_gnt"}, 32'({gnt1, gnt0}), 32'd0);
        chk({tag, "_end_txv"}, 32'(mac_txv), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd1);
        measure_ifg(tag, 12);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tmo, txb;
        step(); step();
        chk("rst_outs", 32'({gnt1, gnt0, mac_txv, busy, err_timeout, err_trunc}), 32'd0);
        chk("rst_txd", 32'(mac_txd), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_outs", 32'({gnt1, gnt0, mac_txv, busy}), 32'd0);

        // Contention: both request together, order 0,1,0,1, foreign bytes must not leak
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            step();
            chk($sformatf("cont%0d_gnt", f), 32'({gnt1, gnt0}), (f % 2 == 0) ? 32'd1 : 32'd2);
            stream(f % 2, 64, 8'(f * 64), 1'b1, -1);
            chk($sformatf("cont%0d_txv", f), 32'(txv_cnt), 32'd64);
            chk($sformatf("cont%0d_dat", f), 32'(bad_cnt), 32'd0);
            if (f == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end_frame($sformatf("cont%0d", f));
        end

        // Single frame of 60 bytes
        req0 = 1'b1;
        step();
        chk("single_gnt", 32'({gnt1, gnt0, busy}), 32'b011);
        req0 = 1'b0;
        stream(0, 60, 8'h00, 1'b0, -1);
        chk("single_txv", 32'(txv_cnt), 32'd60);
        chk("single_dat", 32'(bad_cnt), 32'd0);
        chk("single_gnt_held", 32'(gnt_lo), 32'd0);
        end_frame("single");

        // Start timeout on requester 1
        req1 = 1'b1;
        step();
        chk("tmo_gnt", 32'({gnt1, gnt0}), 32'd2);
        req1 = 1'b0;
        n = 0; tmo = 0; txb = 0;
        while (gnt1 && n < 200) begin
            if (mac_txv) txb++;
            n++;
            step();
            if (err_timeout) tmo++;
        end
        chk("tmo_len", 32'(n), 32'd64);
        chk("tmo_pulses", 32'(tmo), 32'd1);
        chk("tmo_txv", 32'(txb), 32'd0);
        chk("tmo_pulse_now", 32'(err_timeout), 32'd1);
        step();
        chk("tmo_pulse_gone", 32'(err_timeout), 32'd0);
        measure_ifg("tmo", 11);
        req0 = 1'b1;
        step();
        chk("after_tmo_gnt", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0;
        stream(0, 8, 8'hA0, 1'b0, -1);
        chk("after_tmo_txv", 32'(txv_cnt), 32'd8);
        chk("after_tmo_dat", 32'(bad_cnt), 32'd0);
        end_frame("after_tmo");

        // Truncation at 1536 bytes of a 1600-byte stream
        req0 = 1'b1;
        step();
        chk("trunc_gnt", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0;
        stream(0, 1600, 8'h00, 1'b0, -1);
        chk("trunc_txv", 32'(txv_cnt), 32'd1536);
        chk("trunc_dat", 32'(bad_cnt), 32'd0);
        chk("trunc_pulses", 32'(trunc_cnt), 32'd1);
        chk("trunc_gnt_lo", 32'(gnt_lo), 32'd64);
        chk("trunc_busy_fall", 32'(first_idle), 32'd1548);
        vld0 = 1'b0;
        step();
        chk("trunc_after", 32'({gnt1, gnt0, mac_txv, busy}), 32'd0);

        // req0 dropped mid-frame: frame completes, grant ends on vld fall
        req0 = 1'b1;
        step();
        chk("zgap_gnt", 32'({gnt1, gnt0}), 32'd1);
        stream(0, 20, 8'h30, 1'b0, 3);
        chk("zgap_txv", 32'(txv_cnt), 32'd20);
        chk("zgap_dat", 32'(bad_cnt), 32'd0);
        chk("zgap_gnt_held", 32'(gnt_lo), 32'd0);
        end_frame("zgap");

        // Reset at byte 20 of a requester-0 frame
        req0 = 1'b1;
        step();
        chk("rstm_gnt", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0;
        stream(0, 20, 8'h50, 1'b0, -1);
        chk("rstm_txv", 32'(txv_cnt), 32'd20);
        vld0 = 1'b1; dat0 = 8'h64; rst = 1'b1;
        step();
        chk("rstm_outs", 32'({mac_txv, gnt0, gnt1, busy, err_timeout, err_trunc}), 32'd0);
        rst = 1'b0; vld0 = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("rstm_last", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        stream(0, 4, 8'h70, 1'b0, -1);
        chk("rstm_post_txv", 32'(txv_cnt), 32'd4);
        chk("rstm_post_dat", 32'(bad_cnt), 32'd0);
        end_frame("rstm_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
